// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH lines with round-robin valid/ready output and sticky overflow flags.
// Define EDGE_ARB_SYNC_EN to put a two-flop synchronizer on every data bit (adds 2 cycles latency).
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_CH-1:0] data,
    input  logic [N_CH-1:0] ch_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic [N_CH-1:0] ovf,
    input  logic [N_CH-1:0] ovf_clr
);

    logic [N_CH-1:0] samp_s;
    logic [N_CH-1:0] s0_r;
    logic [N_CH-1:0] s1_r;
    logic [N_CH-1:0] pend_r;
    logic [N_CH-1:0] ovf_r;
    logic            evt_valid_r;
    logic [CH_W-1:0] evt_ch_r;
    logic [CH_W-1:0] last_grant_r;

    logic [N_CH-1:0] rise_s;
    logic            load_s;
    logic            found_s;
    logic [CH_W-1:0] winner_s;
    logic [N_CH-1:0] grant_mask_s;
    logic [N_CH-1:0] pend_nxt_s;
    logic [N_CH-1:0] ovf_set_s;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync1_r;
    logic [N_CH-1:0] sync2_r;

    // Two-flop synchronizer for asynchronous data inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= {N_CH{1'b0}};
            sync2_r <= {N_CH{1'b0}};
        end else begin
            sync1_r <= data;
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = sync2_r;
`else
    assign samp_s = data;
`endif

    assign rise_s = s0_r & ~s1_r & ch_en;
    assign load_s = (!evt_valid_r || evt_ready) && (pend_r != {N_CH{1'b0}});

    // Round-robin search: first pending channel at or after last_grant+1, wrapping.
    always_comb begin
        logic [CH_W:0] idx_v;
        winner_s = {CH_W{1'b0}};
        found_s  = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx_v = {1'b0, last_grant_r} + (CH_W+1)'(k);
            if (idx_v >= (CH_W+1)'(N_CH)) begin
                idx_v = idx_v - (CH_W+1)'(N_CH);
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && pend_r[idx_v[CH_W-1:0]]) begin
                winner_s = idx_v[CH_W-1:0];
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pending/overflow next-state; a rise during a load of the same channel re-pends it.
    always_comb begin
        if (load_s) begin
            grant_mask_s = {{(N_CH-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            grant_mask_s = {N_CH{1'b0}};
        end
        pend_nxt_s = (pend_r & ~grant_mask_s) | rise_s;
        ovf_set_s  = rise_s & pend_r & ~grant_mask_s;
    end

    // Sampling pipeline, pending latch, sticky overflow and output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_r         <= {N_CH{1'b0}};
            s1_r         <= {N_CH{1'b0}};
            pend_r       <= {N_CH{1'b0}};
            ovf_r        <= {N_CH{1'b0}};
            evt_valid_r  <= 1'b0;
            evt_ch_r     <= {CH_W{1'b0}};
            last_grant_r <= CH_W'(N_CH-1);
        end else begin
            s0_r   <= samp_s;
            s1_r   <= s0_r;
            pend_r <= pend_nxt_s;
            ovf_r  <= (ovf_r & ~ovf_clr) | ovf_set_s;
            if (load_s) begin
                evt_valid_r  <= 1'b1;
                evt_ch_r     <= winner_s;
                last_grant_r <= winner_s;
            end else if (evt_valid_r && evt_ready) begin
                evt_valid_r  <= 1'b0;
            end else begin
                evt_valid_r  <= evt_valid_r;
            end
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_ch    = evt_ch_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (default build, N_CH = 4).
module tb_edge_event_arbiter;

    logic       clk;
    logic       rstn;
    logic [3:0] data;
    logic [3:0] ch_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data      (data),
        .ch_en     (ch_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; data = 4'h0; ch_en = 4'hF; evt_ready = 1'b1; ovf_clr = 4'h0;
        step(); step();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ch",    32'(evt_ch),    32'd0);
        chk("rst_ovf",   32'(ovf),       32'd0);
        rstn = 1'b1;
        step();

        // single channel pulse, ready high
        data = 4'b0100; step();
        data = 4'b0000;
        chk("single_lat0", 32'(evt_valid), 32'd0);
        step();
        chk("single_lat1", 32'(evt_valid), 32'd0);
        step();
        chk("single_valid", 32'(evt_valid), 32'd1);
        chk("single_ch",    32'(evt_ch),    32'd2);
        step();
        chk("single_drop", 32'(evt_valid), 32'd0);
        chk("single_ovf",  32'(ovf),       32'd0);

        // fairness from a fresh reset
        rstn = 1'b0; step(); rstn = 1'b1; step();
        data = 4'b1111; step();
        data = 4'b0000; step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_valid", 32'(evt_valid), 32'd1);
            chk("fair_ch",    32'(evt_ch),    32'(i));
        end
        step();
        chk("fair_end", 32'(evt_valid), 32'd0);

        // backpressure
        evt_ready = 1'b0;
        data = 4'b0010; step();
        data = 4'b0000; step(); step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(evt_valid), 32'd1);
            chk("bp_hold_ch",    32'(evt_ch),    32'd1);
            step();
        end
        data = 4'b0010; step(); data = 4'b0000; step();
        chk("bp_pend1", 32'(dut.pend_r), 32'b0010);
        chk("bp_ovf0",  32'(ovf),        32'd0);
        data = 4'b0010; step(); data = 4'b0000; step();
        chk("bp_ovf1",  32'(ovf),        32'b0010);
        chk("bp_ch_still", 32'(evt_ch),  32'd1);
        evt_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (evt_valid && evt_ready) begin
                cnt++;
                chk("bp_drain_ch", 32'(evt_ch), 32'd1);
            end
            step();
        end
        chk("bp_drain_cnt", 32'(cnt), 32'd2);

        // overflow clear, then set-vs-clear race
        ovf_clr = 4'b0010; step(); ovf_clr = 4'b0000;
        chk("clr_alone0", 32'(ovf), 32'd0);
        evt_ready = 1'b0;
        data = 4'b0010; step(); data = 4'b0000; step(); step();
        data = 4'b0010; step(); data = 4'b0000; step();
        data = 4'b0010; step(); data = 4'b0000; ovf_clr = 4'b0010; step();
        ovf_clr = 4'b0000;
        chk("race_ovf", 32'(ovf), 32'b0010);
        ovf_clr = 4'b0010; step(); ovf_clr = 4'b0000;
        chk("clr_alone1", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        step(); step(); step();
        chk("race_drained", 32'(evt_valid), 32'd0);

        // enable mask
        ch_en = 4'b1011;
        data = 4'b0100; step(); data = 4'b0000; step(); step(); step();
        chk("mask_valid", 32'(evt_valid),   32'd0);
        chk("mask_pend",  32'(dut.pend_r),  32'd0);
        data = 4'b1000; step(); data = 4'b0000; step(); step();
        chk("mask_valid3", 32'(evt_valid), 32'd1);
        chk("mask_ch3",    32'(evt_ch),    32'd3);
        step();
        ch_en = 4'hF;

        // reset mid-operation with two events pending and an overflow
        evt_ready = 1'b0;
        data = 4'b1110; step(); data = 4'b0000; step(); step();
        data = 4'b0100; step(); data = 4'b0000; step();
        chk("mid_valid", 32'(evt_valid),  32'd1);
        chk("mid_ch",    32'(evt_ch),     32'd1);
        chk("mid_pend",  32'(dut.pend_r), 32'b1100);
        chk("mid_ovf",   32'(ovf),        32'b0100);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid),  32'd0);
        chk("mid_rst_pend",  32'(dut.pend_r), 32'd0);
        chk("mid_rst_ovf",   32'(ovf),        32'd0);
        data = 4'b1001; evt_ready = 1'b1;
        step();
        rstn = 1'b1;
        step();
        data = 4'b0000; step(); step();
        chk("post_rst_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_ch0",   32'(evt_ch),    32'd0);
        step();
        chk("post_rst_ch3",   32'(evt_ch),    32'd3);
        step();
        chk("post_rst_end",   32'(evt_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event controller for the positive-edge detection datapath. It detects rising edges on `N_CH` independent `data` lines and latches each as a pending event. It then arbitrates pending events round-robin onto a single valid/ready event port consumed by downstream logic. Events that arrive while the same channel is already pending are counted as lost and flagged in a sticky overflow register.

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `CH_W`, default `$clog2(N_CH)`: channel-index width (derived; do not override).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `data`  in  N_CH  level inputs, one per channel; may be asynchronous when `EDGE_ARB_SYNC_EN` is defined.
- `ch_en`  in  N_CH  per-channel enable; a rise on a disabled channel is ignored.
- `evt_valid`  out  1  event available on `evt_ch`.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ch`  out  CH_W  index of the channel that produced the presented event.
- `ovf`  out  N_CH  sticky per-channel lost-event flags.
- `ovf_clr`  in  N_CH  per-bit clear for `ovf`, synchronous, 1-cycle pulse.

## Operation
- **Sampling pipeline:** `s0 <= data` (or the synchronizer output, see Configuration) and `s1 <= s0`. A rise is `s0 & ~s1 & ch_en`.
- **Pending register:** `pend[i]` is set on a rise of channel i and cleared when channel i is loaded into the output register.
  - A rise in the same cycle as a load of channel i leaves `pend[i]` = 1 (a new event).
  - A rise while `pend[i]` = 1 and channel i is not being loaded sets `ovf[i]`; the event is lost.
  - Deasserting `ch_en[i]` does not clear an existing `pend[i]`.
- **Output register:** holds `evt_valid`/`evt_ch`. A load occurs when (`!evt_valid` or `evt_ready`) and `pend` != 0.
  - On a load, `evt_valid` <= 1 and `evt_ch` <= the winner.
  - If `evt_valid & evt_ready` and `pend` == 0, `evt_valid` <= 0.
  - Back-to-back transfers at one event per cycle are supported.
- **Round-robin arbitration:** the search starts at `(last_grant + 1) mod N_CH` and wraps to the lowest set bit above or at that index. `last_grant` resets to `N_CH-1`, so channel 0 wins first after reset.
- **Stability:** while `evt_valid` = 1 and `evt_ready` = 0, `evt_ch` and `evt_valid` hold stable.
- **`ovf` updates:** a set takes priority over `ovf_clr` in the same cycle.

## Timing
- **Reset values:** `evt_valid` = 0, `evt_ch` = 0, `ovf` = 0, `pend` = 0, `s0` = `s1` = 0, synchronizer flops = 0, `last_grant` = `N_CH-1`.
- **Data high at reset release:** `data` high when `rstn` deasserts is treated as a rising edge.
- **Latency without sync:** `data` rises before clock edge k → `s0` = 1 after k → `pend` set at k+1 → `evt_valid` = 1 after k+2 if the output register is free. That is 2 cycles after the sampling edge.
- **Latency with sync:** 2 additional cycles.
- **Minimum pulse width without sync:** 1 clock period for the rise to be seen.
- **Simultaneous rises:** all rises in one cycle are pended in that cycle and granted in round-robin order over successive cycles.
- **Reset mid-operation:** asynchronous; all state clears immediately and any presented event is dropped.

## Configuration
- `EDGE_ARB_SYNC_EN`
  - **Defined:** each `data` bit passes through a two-flop synchronizer before `s0`; total event latency is 4 cycles.
  - **Undefined:** `data` feeds `s0` directly. Inputs must be synchronous to `clk`; latency is 2 cycles.

## Test plan
- Reset, then single channel, `evt_ready` = 1: pulse `data[2]` for 1 cycle → `evt_valid` high for exactly 1 cycle with `evt_ch` = 2, 2 cycles after sampling (4 with `EDGE_ARB_SYNC_EN`); `ovf` = 0.
- Fairness: raise `data[3:0]` = 4'b1111 in one cycle with `evt_ready` = 1 → `evt_ch` sequence 0,1,2,3 on 4 consecutive cycles, then `evt_valid` = 0.
- Backpressure: `evt_ready` = 0, pulse ch1 → `evt_valid` = 1 with `evt_ch` = 1 held stable for 10 cycles. Pulse ch1 twice more → `ovf[1]` = 1 and one event stays pending. After `evt_ready` = 1 → exactly 2 events with `evt_ch` = 1.
- Overflow clear race: pulse `ovf_clr[1]` in the same cycle as a new overflow on ch1 → `ovf[1]` stays 1. A later `ovf_clr[1]` alone → `ovf[1]` = 0.
- Enable mask: `ch_en` = 4'b1011, pulse `data[2]` → no event. Then pulse `data[3]` → `evt_ch` = 3.
- Reset mid-operation: assert `rstn` low while `evt_valid` = 1 with 2 events pending → `evt_valid`, `pend` and `ovf` all 0 immediately; after release the next grant goes to channel 0 first.
